fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO, successor to the single-port read_or_write FIFO.
//  Separate write/read enables allow a simultaneous push and pop in one cycle.
//  Adds almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags.
//  Sits between a bursty producer and a consumer in the same clock domain.
// PARAMETERS
//  WIDTH        32  data word width in bits
//  DEPTH        32  number of entries; power of two, >= 2
//  ADDR_WIDTH   5   log2(DEPTH)
//  AF_THRESH    28  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH    4   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clock         in   1             single clock, rising edge
//  reset         in   1             synchronous, active-high
//  write_en      in   1             push request
//  data_in       in   WIDTH         push data
//  read_en       in   1             pop request
//  data_out      out  WIDTH         popped data, registered
//  data_valid    out  1             data_out holds a word popped in the previous cycle
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_THRESH
//  almost_empty  out  1             count <= AE_THRESH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: a push was rejected
//  underflow     out  1             sticky: a pop was rejected
//  clear_errors  in   1             clears overflow/underflow
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - Reset: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0,
//    data_out=0, data_valid=0, overflow=0, underflow=0. Storage array is not reset.
//  - Reset asserted mid-operation discards all contents on that edge. Requests in that cycle are ignored.
//  - rd_ok = read_en & !empty
//  - wr_ok = write_en & (!full | rd_ok). When full, a push is accepted only together with a pop.
//  - No bypass when empty: a push+pop in the same cycle while empty performs the push only. underflow is set.
//  - Write: on wr_ok, mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in, then wr_ptr += 1.
//  - Read: on rd_ok, data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]], then rd_ptr += 1.
//  - Read latency is 1 cycle: data_valid=1 in the cycle after rd_ok, else 0. data_out holds its last value otherwise.
//  - Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. Index uses the low ADDR_WIDTH bits.
//  - count next value: +1 (wr_ok only), -1 (rd_ok only), unchanged (both or neither).
//  - full, empty, almost_full and almost_empty are registered. They are computed from count's next value,
//    so they are always consistent with count in the same cycle.
//  - overflow <= 1 when write_en & !wr_ok. underflow <= 1 when read_en & empty.
//  - clear_errors clears both flags. A set in the same cycle takes priority over the clear.
//  - Contents and ordering are never corrupted by a rejected request.
// TESTING
//  1. Reset, then push 1..32 -> count 32, full=1; almost_full rises when count reaches 28. Pop all 32
//     -> data_out 1..32 in order, each one cycle after its pop; empty=1 at the end.
//  2. Fill to 32, then push 0xDEAD with no pop -> overflow=1, count stays 32, contents unchanged.
//     Pop on an empty FIFO -> underflow=1, data_valid=0.
//  3. Fill to 32, then push 0xAA and pop in the same cycle -> count stays 32, full=1,
//     and 0xAA is read 32 pops later.
//  4. Wrap-around: run 100 cycles of continuous push+pop with count held at 5
//     -> output sequence matches the input sequence; pointers wrap with no data loss.
//  5. Reset asserted mid-burst at count=12 -> next cycle count=0, empty=1, data_valid=0, error flags 0.
//  6. Assert clear_errors while overflow=1 -> flag clears. Same cycle as a new overflow event -> flag stays 1.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with simultaneous push/pop, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_param #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int AF_THRESH  = 28,
   parameter int AE_THRESH  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  read_en,
   output logic [WIDTH-1:0]      data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clear_errors
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C   = CW'(1);

   logic [WIDTH-1:0]    mem [DEPTH];

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic [WIDTH-1:0]    data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                af_q, af_d;
   logic                ae_q, ae_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic                rd_ok, wr_ok;

   // A push into a full FIFO is only legal when a pop frees a slot.
   always_comb begin
      rd_ok = read_en & ~empty_q;
      wr_ok = write_en & (~full_q | rd_ok);
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_out_d   = data_out_q;
      data_valid_d = rd_ok;
      if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_C;
      if (rd_ok) begin
         rd_ptr_d   = rd_ptr_q + ONE_C;
         data_out_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
      if (wr_ok & ~rd_ok) count_d = count_q + ONE_C;
      if (rd_ok & ~wr_ok) count_d = count_q - ONE_C;
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AF_C);
      ae_d    = (count_d <= AE_C);
   end

   // Setting an error flag wins over clearing it in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (clear_errors) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (write_en & ~wr_ok) ovf_d = 1'b1;
      if (read_en & empty_q) unf_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         af_q         <= 1'b0;
         ae_q         <= 1'b1;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         af_q         <= af_d;
         ae_q         <= ae_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wr_ok) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo_sync_param;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = 5;
   localparam int AF = 28;
   localparam int AE = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          write_en = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic          read_en = 1'b0;
   logic          clear_errors = 1'b0;
   logic [W-1:0]  data_out;
   logic          data_valid, full, empty;
   logic          almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow, underflow;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout;
   logic         m_dv, m_ovf, m_unf;

   fifo_sync_param #(
      .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW),
      .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clock(clock), .reset(reset),
      .write_en(write_en), .data_in(data_in),
      .read_en(read_en), .data_out(data_out),
      .data_valid(data_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .clear_errors(clear_errors)
   );

   always #5 clock = ~clock;

   // Drive one clock of stimulus and advance the reference model.
   task automatic cycle(input logic we, input logic [W-1:0] din,
                        input logic re, input logic clr,
                        input logic rst);
      bit was_empty, rd_ok, wr_ok;
      write_en = we; data_in = din; read_en = re;
      clear_errors = clr; reset = rst;
      if (rst) begin
         mq.delete();
         m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         was_empty = (mq.size() == 0);
         rd_ok = re && !was_empty;
         wr_ok = we && (mq.size() < D || rd_ok);
         m_dv = rd_ok;
         if (rd_ok) m_dout = mq.pop_front();
         if (wr_ok) mq.push_back(din);
         if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
         if (we && !wr_ok) m_ovf = 1'b1;
         if (re && was_empty) m_unf = 1'b1;
      end
      @(posedge clock);
      #1;
      write_en = 1'b0; read_en = 1'b0;
      clear_errors = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (count !== '0) begin
         errors++;
         $display("FAIL reset_count got=%0d exp=0", count);
      end
      checks++;
      if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=0101",
                  {full, empty, almost_full, almost_empty});
      end
      checks++;
      if ({data_valid, overflow, underflow, data_out} !== '0) begin
         errors++;
         $display("FAIL reset_out dv=%b ovf=%b unf=%b dout=%h exp=0",
                  data_valid, overflow, underflow, data_out);
      end
   endtask

   task automatic test_fill_drain();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= D; i++) begin
         cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
         checks++;
         if (count !== (AW+1)'(i) || full !== (i == D) ||
             almost_full !== (i >= AF) || almost_empty !== (i <= AE)) begin
            errors++;
            $display("FAIL fill_%0d cnt=%0d f=%b af=%b ae=%b exp cnt=%0d",
                     i, count, full, almost_full, almost_empty, i);
         end
      end
      for (int i = 1; i <= D; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (data_valid !== 1'b1 || data_out !== W'(i)) begin
            errors++;
            $display("FAIL drain_%0d dv=%b dout=%0d exp dv=1 dout=%0d",
                     i, data_valid, data_out, i);
         end
      end
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (empty !== 1'b1 || data_valid !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL drain_end empty=%b dv=%b cnt=%0d exp 1 0 0",
                  empty, data_valid, count);
      end
   endtask

   task automatic test_overflow_underflow();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1 || count !== (AW+1)'(D) || full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set ovf=%b cnt=%0d full=%b exp 1 %0d 1",
                  overflow, count, full, D);
      end
      for (int i = 1; i <= D; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (data_out !== W'(i) || data_out !== m_dout) begin
            errors++;
            $display("FAIL ovf_contents_%0d got=%h exp=%h", i, data_out, i);
         end
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (underflow !== 1'b1 || data_valid !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL unf_set unf=%b dv=%b cnt=%0d exp 1 0 0",
                  underflow, data_valid, count);
      end
   endtask

   task automatic test_full_push_pop();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < D; i++) cycle(1'b1, W'(100 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== (AW+1)'(D) || full !== 1'b1 || overflow !== 1'b0 ||
          data_out !== W'(100)) begin
         errors++;
         $display("FAIL full_pp cnt=%0d full=%b ovf=%b dout=%0d exp %0d 1 0 100",
                  count, full, overflow, data_out, D);
      end
      for (int i = 1; i <= D; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (data_out !== ((i == D) ? W'(32'hAA) : W'(100 + i))) begin
            errors++;
            $display("FAIL full_pp_pop_%0d got=%h model=%h", i, data_out, m_dout);
         end
      end
   endtask

   task automatic test_wrap();
      int bad = 0;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
         checks++;
         if (data_valid !== 1'b1 || data_out !== m_dout ||
             count !== (AW+1)'(5)) begin
            errors++;
            bad++;
            if (bad < 5)
               $display("FAIL wrap_%0d dout=%h exp=%h cnt=%0d dv=%b",
                        i, data_out, m_dout, count, data_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
      checks++;
      if (count !== '0 || empty !== 1'b1 || data_valid !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid cnt=%0d empty=%b dv=%b ovf=%b unf=%b",
                  count, empty, data_valid, overflow, underflow);
      end
      cycle(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (data_out !== 32'h1234 || count !== '0) begin
         errors++;
         $display("FAIL reset_mid_after dout=%h cnt=%0d exp 1234 0",
                  data_out, count);
      end
   endtask

   task automatic test_clear_errors();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_ovf got=%b exp=0", overflow);
      end
      cycle(1'b1, 32'h2, 1'b0, 1'b1, 1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_set_ovf got=%b exp=1", overflow);
      end
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_set_unf got=%b exp=1", underflow);
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (underflow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_unf unf=%b ovf=%b exp 0 0", underflow, overflow);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      int c;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         logic we, re, clr;
         // Phase-biased traffic so the FIFO visits both full and empty.
         if ((i / 100) % 2 == 0) begin
            we = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) == 0);
         end else begin
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) != 0);
         end
         clr = ($urandom_range(0, 15) == 0);
         cycle(we, W'($urandom), re, clr, 1'b0);
         c = mq.size();
         checks++;
         if (count !== (AW+1)'(c) || full !== (c == D) || empty !== (c == 0) ||
             almost_full !== (c >= AF) || almost_empty !== (c <= AE) ||
             data_valid !== m_dv || data_out !== m_dout ||
             overflow !== m_ovf || underflow !== m_unf) begin
            errors++;
            bad++;
            if (bad < 5)
               $display("FAIL rand_%0d cnt=%0d/%0d dout=%h/%h dv=%b/%b ovf=%b/%b unf=%b/%b",
                        i, count, c, data_out, m_dout, data_valid, m_dv,
                        overflow, m_ovf, underflow, m_unf);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
      test_clear_errors();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
